// File: rtl/gray_box_pool.sv
// Block-average downsampler: crops a centred 28*WIN square window from the raster
// and emits one 8-bit mean per WIN x WIN tile, 784 per frame, with an end pulse.
module gray_box_pool #(
    parameter int CROP_X0  = 96,
    parameter int CROP_Y0  = 16,
    parameter int LOG2_WIN = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    input  logic [9:0]  iX,
    input  logic [9:0]  iY,
    output logic [7:0]  oDATA,
    output logic        oDVAL,
    output logic [4:0]  oX,
    output logic [4:0]  oY,
    output logic        oDONE
);
    localparam int          WIN      = 1 << LOG2_WIN;
    localparam int          AW       = 12 + 2 * LOG2_WIN;
    localparam logic [9:0]  X0       = 10'(CROP_X0);
    localparam logic [9:0]  Y0       = 10'(CROP_Y0);
    localparam logic [9:0]  SPAN     = 10'(28 * WIN);
    localparam logic [9:0]  N_OUT    = 10'd784;
    localparam logic [9:0]  LAST_OUT = 10'd783;

    // Negative offsets wrap to large unsigned values and fail the span test.
    logic [9:0]          dx, dy;
    logic                in_win;
    logic [LOG2_WIN-1:0] xo, yo;

    assign dx     = iX - X0;
    assign dy     = iY - Y0;
    assign in_win = (dx < SPAN) && (dy < SPAN);
    assign xo     = dx[LOG2_WIN-1:0];
    assign yo     = dy[LOG2_WIN-1:0];

    logic        s1_val, s1_first, s1_last, fval_q;
    logic [4:0]  s1_col, s1_row;
    logic [11:0] s1_data;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_val   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_data  <= '0;
            fval_q   <= 1'b0;
        end else begin
            fval_q   <= iFVAL;
            s1_val   <= iDVAL && in_win;
            s1_first <= (xo == '0) && (yo == '0);
            s1_last  <= (xo == '1) && (yo == '1);
            s1_col   <= 5'(dx >> LOG2_WIN);
            s1_row   <= 5'(dy >> LOG2_WIN);
            s1_data  <= iDATA;
        end
    end

    logic [AW-1:0] acc [28];
    logic [AW-1:0] sum;
    logic [11:0]   mean;
    logic [9:0]    cnt, cnt_base;
    logic          frame_start, emit;

    assign sum         = acc[s1_col] + AW'(s1_data);
    assign mean        = 12'(sum >> (2 * LOG2_WIN));
    assign frame_start = iFVAL && !fval_q;
    // A frame start clears the count before any tile completing in the same cycle.
    assign cnt_base    = frame_start ? '0 : cnt;
    assign emit        = s1_val && s1_last && (cnt_base != N_OUT);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < 28; i++) acc[i] <= '0;
            cnt   <= '0;
            oDATA <= '0;
            oDVAL <= 1'b0;
            oX    <= '0;
            oY    <= '0;
            oDONE <= 1'b0;
        end else begin
            oDVAL <= emit;
            oDONE <= emit && (cnt_base == LAST_OUT);
            cnt   <= emit ? cnt_base + 10'd1 : cnt_base;
            if (s1_val) acc[s1_col] <= s1_first ? AW'(s1_data) : sum;
            if (emit) begin
                oDATA <= mean[11:4];
                oX    <= s1_col;
                oY    <= s1_row;
            end
        end
    end
endmodule

// File: tb/tb_gray_box_pool.sv
// Scoreboard bench for gray_box_pool: frames are built as images, tile means are
// computed from the image and queued, and a negedge monitor checks every output.
module tb_gray_box_pool;
    localparam int L    = 1;
    localparam int X0   = 96;
    localparam int Y0   = 16;
    localparam int SPAN = 56;
    localparam int RX0  = 90;
    localparam int NX   = 68;
    localparam int RY0  = 12;
    localparam int NY   = 64;

    logic        iCLK = 1'b0;
    logic        iRST, iFVAL, iDVAL;
    logic [11:0] iDATA;
    logic [9:0]  iX, iY;
    logic [7:0]  oDATA;
    logic        oDVAL, oDONE;
    logic [4:0]  oX, oY;

    gray_box_pool #(.CROP_X0(X0), .CROP_Y0(Y0), .LOG2_WIN(L)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
        .iX(iX), .iY(iY), .oDATA(oDATA), .oDVAL(oDVAL), .oX(oX), .oY(oY), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [7:0] d;
        logic [4:0] x;
        logic [4:0] y;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          cyc = 0;
    int          vectors = 0, errors = 0;
    int          obs_dval = 0, obs_done = 0, mcnt = 0;
    logic [11:0] img [NY][NX];

    always @(posedge iCLK) cyc = cyc + 1;

    always @(negedge iCLK) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            me = q.pop_front();
            vectors++; errors++;
            $display("FAIL missing_out tile (%0d,%0d): no oDVAL, required at cycle %0d", me.x, me.y, me.cyc);
        end
        if (oDONE && !oDVAL) begin
            vectors++; errors++;
            $display("FAIL done_alone cyc %0d: oDONE=1 with oDVAL=0, required oDVAL=1", cyc);
        end
        if (oDVAL) begin
            obs_dval++;
            if (oDONE) obs_done++;
            if (q.size() == 0) begin
                vectors++; errors++;
                $display("FAIL unexpected_out cyc %0d: got d=%h x=%0d y=%0d, required no output", cyc, oDATA, oX, oY);
            end else begin
                me = q.pop_front();
                vectors++;
                if (oDATA !== me.d || oX !== me.x || oY !== me.y || oDONE !== me.done || me.cyc != cyc) begin
                    errors++;
                    $display("FAIL tile_out got d=%h x=%0d y=%0d done=%0b cyc=%0d, required d=%h x=%0d y=%0d done=%0b cyc=%0d",
                             oDATA, oX, oY, oDONE, cyc, me.d, me.x, me.y, me.done, me.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_zero(string name);
        vectors++;
        if ({oDATA, oDVAL, oX, oY, oDONE} !== '0) begin
            errors++;
            $display("FAIL %s got d=%h v=%0b x=%0d y=%0d done=%0b, required all 0", name, oDATA, oDVAL, oX, oY, oDONE);
        end
    endtask

    // 0 constant, 1 tile-distinct, 2 out-of-window 0xFFF, 3 X+Y[1:0], 4 random
    task automatic build(int mode);
        for (int r = 0; r < NY; r++)
            for (int c = 0; c < NX; c++) begin
                int x, y, dx, dy;
                bit inw;
                x = RX0 + c; y = RY0 + r; dx = x - X0; dy = y - Y0;
                inw = dx >= 0 && dx < SPAN && dy >= 0 && dy < SPAN;
                case (mode)
                    0: img[r][c] = 12'hABC;
                    1: img[r][c] = inw ? 12'(256 * (1 + dx % 2 + 2 * (dy % 2))) : 12'($urandom);
                    2: img[r][c] = inw ? 12'h000 : 12'hFFF;
                    3: img[r][c] = 12'(x + (y % 4));
                    default: img[r][c] = 12'($urandom);
                endcase
            end
    endtask

    task automatic run_frame(int mode, int max_gap, int stop_at, bit do_rst);
        bit halt;
        int exp_n;
        halt = 0;
        build(mode);
        iFVAL = 0; iDVAL = 0;
        tick(); tick();
        iFVAL = 1; mcnt = 0; obs_dval = 0; obs_done = 0;
        tick();
        for (int y = RY0; y < RY0 + NY && !halt; y++)
            for (int x = RX0; x < RX0 + NX && !halt; x++) begin
                int dx, dy, sum;
                exp_t e;
                dx = x - X0; dy = y - Y0;
                iX = 10'(x); iY = 10'(y); iDATA = img[y - RY0][x - RX0]; iDVAL = 1;
                if (dx >= 0 && dx < SPAN && dy >= 0 && dy < SPAN && dx % 2 == 1 && dy % 2 == 1 && mcnt < 784) begin
                    sum = img[y-RY0][x-RX0] + img[y-RY0][x-RX0-1] + img[y-RY0-1][x-RX0] + img[y-RY0-1][x-RX0-1];
                    e.d = 8'(sum / 64); e.x = 5'(dx / 2); e.y = 5'(dy / 2);
                    e.done = (mcnt == 783); e.cyc = cyc + 2;
                    q.push_back(e);
                    mcnt++;
                end
                tick();
                if (mcnt == stop_at) halt = 1;
                iDVAL = 0; iDATA = 12'($urandom);
                if (!halt) repeat ($urandom_range(max_gap, 0)) tick();
            end
        iDVAL = 0;
        repeat (4) tick();
        exp_n = stop_at < 784 ? stop_at : 784;
        vectors++;
        if (obs_dval != exp_n) begin
            errors++;
            $display("FAIL frame_count mode %0d got %0d outputs, required %0d", mode, obs_dval, exp_n);
        end
        vectors++;
        if (obs_done != (exp_n == 784 ? 1 : 0)) begin
            errors++;
            $display("FAIL frame_done mode %0d got %0d oDONE, required %0d", mode, obs_done, exp_n == 784 ? 1 : 0);
        end
        if (do_rst) begin
            iRST = 1;
            repeat (3) begin
                #2;
                check_zero("reset_outputs");
                tick();
            end
            iRST = 0;
            tick();
        end
        iFVAL = 0;
    endtask

    initial begin
        iRST = 1; iFVAL = 0; iDVAL = 0; iDATA = '0; iX = '0; iY = '0;
        repeat (3) tick();
        check_zero("reset_state");
        iRST = 0;
        tick();
        run_frame(0, 0, 9999, 0);
        run_frame(1, 0, 9999, 0);
        run_frame(2, 0, 9999, 0);
        run_frame(3, 5, 9999, 0);
        run_frame(3, 0, 9999, 0);
        run_frame(4, 2, 300, 0);
        run_frame(4, 0, 9999, 0);
        run_frame(4, 1, 400, 1);
        run_frame(4, 0, 9999, 0);
        repeat (4) tick();
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty got %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/gray_box_pool.md
# gray_box_pool

Block-average downsampler between the RAW2GRAY grayscale stage and the image-capture FSM. Consumes the half-resolution 12-bit grayscale raster stream, selects a centred square window of 28·WIN × 28·WIN pixels, and averages each WIN×WIN tile into one 8-bit output pixel. Emits 784 pixels per frame in raster order with tile coordinates and an end-of-image pulse. This replaces point-sampling in front of the DMEM packer.

## Interface
- CROP_X0, 96: first window column, half-res X coordinate.
- CROP_Y0, 16: first window row, half-res Y coordinate.
- LOG2_WIN, 4: log2 of tile edge; WIN = 2^LOG2_WIN, legal 1..4.
- iCLK  in  1: pixel clock (D5M_PIXLCLK domain).
- iRST  in  1: asynchronous, active-high reset.
- iFVAL  in  1: frame valid; its rising edge starts a new frame.
- iDVAL  in  1: input pixel valid; may be high every cycle.
- iDATA  in  12: grayscale pixel.
- iX  in  10: pixel column, half-res.
- iY  in  10: pixel row, half-res.
- oDATA  out  8: tile mean, bits [11:4] of the 12-bit mean.
- oDVAL  out  1: one-cycle strobe, oDATA/oX/oY valid.
- oX  out  5: tile column 0..27.
- oY  out  5: tile row 0..27.
- oDONE  out  1: one-cycle pulse, coincident with the 784th oDVAL of a frame.

## Operation
- Stage 1 registers the inputs and computes the window offsets dx = iX−CROP_X0 and dy = iY−CROP_Y0.
  - in_win: dx and dy both lie in 0..28·WIN−1. Pixels outside the window are dropped.
  - Tile column col = dx>>LOG2_WIN. Sub-offsets xo = dx[LOG2_WIN−1:0] and yo = dy[LOG2_WIN−1:0].
  - Tile row = dy>>LOG2_WIN.
- Accumulator array: 28 flop entries, each 12+2·LOG2_WIN bits wide (20 at default). The array is not a RAM, so the same entry can be read and written on consecutive cycles.
- Stage 2 updates the accumulator for each in-window valid pixel:
  - xo==0 and yo==0: acc[col] ← pixel (load, discards the previous tile).
  - Otherwise: acc[col] ← acc[col] + pixel.
  - xo==WIN−1 and yo==WIN−1: this is the last pixel of the tile.
    - sum = acc[col] + pixel; mean = sum >> (2·LOG2_WIN), 12 bits.
    - Register oDATA = mean[11:4], oX = col, oY = tile row; pulse oDVAL.
- Output counter, 10 bits:
  - Increments on each oDVAL.
  - oDONE pulses when the counter goes from 783 to 784.
  - The counter saturates at 784; no further oDVAL is emitted until the next frame.
- Frame control:
  - An iFVAL rising edge, detected against the registered iFVAL, clears the output counter.
  - Accumulators are not cleared; tile-start loads make clearing unnecessary.
- Input order: pixels arrive in raster order. Missing or reordered pixels corrupt only the affected tiles; behaviour stays bounded and there is no lockup.

## Timing
- Reset values: oDATA=0, oDVAL=0, oX=0, oY=0, oDONE=0. Counter, accumulators and pipeline registers all 0.
- Latency: oDVAL is asserted 2 iCLK cycles after the iDVAL of a tile's last pixel.
- Throughput: one input pixel per cycle, no stall and no backpressure. At most one oDVAL per WIN input pixels.
- Back-to-back pixels in the same column: the stage-2 read-modify-write completes each cycle, with no hazard.
- iDVAL gaps of any length have no effect. State is held between valid pixels.
- iFVAL rising edge in the same cycle as an in-window pixel: the counter clears first, and that pixel is processed normally.
- Frame aborted early (iFVAL falls before 784 outputs): no oDONE. The next rising edge restarts the count.
- iRST asserted mid-frame: all outputs drop to their reset values asynchronously. After release, outputs resume at the next tile boundary; the count restarts only at the next iFVAL rise.
- Boundary rows and columns: dx = 28·WIN−1 and dy = 28·WIN−1 are in window; dx = 28·WIN is out. Negative differences wrap to large unsigned values and are rejected.

## Test plan
- Constant frame: iDATA=0xABC for every pixel of a 640×480 raster, default parameters.
  - Exactly 784 oDVAL, all with oDATA=0xAB.
  - Raster order (0,0)…(27,27).
  - oDONE pulses once, with the last oDVAL.
- Tile-distinct pattern: LOG2_WIN=1, each 2×2 tile filled with {0x100,0x200,0x300,0x400}.
  - Every oDATA=0x28 (mean 0x280).
  - Each oDVAL appears 2 cycles after that tile's 4th pixel.
- Out-of-window rejection: pixels outside the window set to 0xFFF, in-window pixels set to 0x000.
  - All outputs are 0x00.
  - Edge tiles (0,0) and (27,27) are unaffected.
- Gapped input: random iDVAL gaps of 0–5 cycles, data iDATA=iX[9:0]+iY[1:0].
  - Outputs are bit-identical to a golden model and to the same stream with no gaps.
- Abort and restart: iFVAL falls after 300 outputs, then a full frame follows.
  - No oDONE in the first frame.
  - The second frame gives 784 outputs and one oDONE.
- Reset mid-frame: assert iRST for 3 cycles at output 400.
  - Outputs are 0 during reset.
  - The next full frame gives 784 correct outputs and an oDONE.
